// File: rtl/eig_req_ctrl.sv
// Request controller for an iterative eigen core: queues coefficient pairs, launches one
// core request at a time, and holds each result (or an abort record) until downstream takes it.
module eig_req_ctrl #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W-1:0]        in_a0,
    input  logic signed [W-1:0]        in_a1,
    output logic                       core_data_rdy,
    output logic signed [W-1:0]        core_a0,
    output logic signed [W-1:0]        core_a1,
    input  logic                       core_busy,
    input  logic signed [W-1:0]        core_kappa,
    input  logic signed [W-1:0]        core_inv_kappa,
    input  logic [2:0]                 core_regime,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [W-1:0]        out_kappa,
    output logic signed [W-1:0]        out_inv_kappa,
    output logic [2:0]                 out_regime,
    output logic                       out_timeout,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [2:0]                 state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic signed [W-1:0] mem_a0 [DEPTH];
    logic signed [W-1:0] mem_a1 [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                push, pop;
    logic                capture, abort;
    logic                settle_cnt;
    logic [TW-1:0]       timer;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high (and ena
    // is high); ready never depends on valid, and out_valid is held until out_ready is seen.
    assign in_ready      = ena && !rst && (fifo_count < CW'(DEPTH));
    assign push          = in_valid && in_ready;
    assign core_data_rdy = ena && (state == S_LAUNCH);
    assign out_valid     = (state == S_HOLD);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a0[wr_ptr] <= in_a0;
            mem_a1[wr_ptr] <= in_a1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop      = ena;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nx = S_SETTLE;
            // core_busy is only meaningful two cycles after the request pulse
            S_SETTLE: begin
                if (settle_cnt) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!core_busy) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end else if (timer == T_LAST) begin
                    abort    = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt    <= 1'b0;
            timer         <= '0;
            core_a0       <= '0;
            core_a1       <= '0;
            out_kappa     <= '0;
            out_inv_kappa <= '0;
            out_regime    <= 3'b000;
            out_timeout   <= 1'b0;
        end else if (ena) begin
            if (pop) begin
                core_a0 <= mem_a0[rd_ptr];
                core_a1 <= mem_a1[rd_ptr];
            end
            settle_cnt <= (state == S_SETTLE) && !settle_cnt;
            // Any non-WAIT cycle clears the timer, so it always starts at zero in WAIT
            if (state == S_WAIT) timer <= timer + TW'(1);
            else                 timer <= '0;
            if (capture) begin
                out_kappa     <= core_kappa;
                out_inv_kappa <= core_inv_kappa;
                out_regime    <= core_regime;
                out_timeout   <= 1'b0;
            end else if (abort) begin
                out_kappa     <= '0;
                out_inv_kappa <= '0;
                out_regime    <= 3'b000;
                out_timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eig_req_ctrl.sv
// Self-checking bench for eig_req_ctrl: vector table of single requests, multi-cycle corner
// sequences, and a randomized run against a queue-based model of the controller's contract.
module tb_eig_req_ctrl;

    localparam int W       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk, rst, ena;
    logic in_valid, in_ready;
    logic [W-1:0] in_a0, in_a1;
    logic core_data_rdy;
    logic [W-1:0] core_a0, core_a1;
    logic core_busy;
    logic [W-1:0] core_kappa, core_inv_kappa;
    logic [2:0] core_regime;
    logic out_valid, out_ready;
    logic [W-1:0] out_kappa, out_inv_kappa;
    logic [2:0] out_regime;
    logic out_timeout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [2:0] state_dbg;

    eig_req_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_a0(in_a0), .in_a1(in_a1),
        .core_data_rdy(core_data_rdy), .core_a0(core_a0), .core_a1(core_a1),
        .core_busy(core_busy), .core_kappa(core_kappa), .core_inv_kappa(core_inv_kappa),
        .core_regime(core_regime),
        .out_valid(out_valid), .out_ready(out_ready), .out_kappa(out_kappa),
        .out_inv_kappa(out_inv_kappa), .out_regime(out_regime), .out_timeout(out_timeout),
        .fifo_count(fifo_count), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed { logic [31:0] a0; logic [31:0] a1; } req_t;
    typedef struct packed { logic [31:0] k; logic [31:0] i; logic [2:0] r; logic to; } res_t;

    req_t req_q[$];
    res_t exp_q[$];
    int   n_push = 0;
    int   n_out  = 0;

    // ---------------- core model and reference ----------------
    // The core answers each request after lat cycles of busy. Reference rule: with ena held
    // high, the controller sees busy drop in time iff lat <= TIMEOUT+1; otherwise it aborts.
    bit          lat_fixed, resp_fixed;
    int          prog_lat;
    logic [31:0] prog_kappa, prog_inv;
    logic [2:0]  prog_regime;
    int          busy_cnt = 0;
    int          m_lat;
    req_t        m_req;
    res_t        m_res;
    logic [31:0] m_k, m_i;
    logic [2:0]  m_r;

    assign core_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (core_data_rdy === 1'b1) begin
            m_lat = lat_fixed ? prog_lat : int'($urandom_range(1, 20));
            m_k = '0; m_i = '0; m_r = '0;
            if (req_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL core_req: request pulse with no pending push, got 1 pulse, expected 0 (cycle %0d)", cyc);
            end else begin
                m_req = req_q.pop_front();
                chk("core_a0", 64'(core_a0), 64'(m_req.a0));
                chk("core_a1", 64'(core_a1), 64'(m_req.a1));
                if (resp_fixed) begin
                    m_k = prog_kappa; m_i = prog_inv; m_r = prog_regime;
                end else begin
                    m_k = m_req.a0 + m_req.a1;
                    m_i = m_req.a0 ^ m_req.a1;
                    m_r = 3'b001 << (m_req.a0 % 3);
                end
                if (m_lat > TIMEOUT + 1) m_res = '{k: '0, i: '0, r: 3'b000, to: 1'b1};
                else                     m_res = '{k: m_k, i: m_i, r: m_r, to: 1'b0};
                exp_q.push_back(m_res);
            end
            core_kappa     <= m_k;
            core_inv_kappa <= m_i;
            core_regime    <= m_r;
            busy_cnt       <= m_lat;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    res_t sb_e;
    always @(negedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            req_q.push_back('{a0: in_a0, a1: in_a1});
            n_push++;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_order: result with no outstanding request, got kappa %0h, expected none (cycle %0d)", out_kappa, cyc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_kappa", 64'(out_kappa), 64'(sb_e.k));
                chk("sb_inv_kappa", 64'(out_inv_kappa), 64'(sb_e.i));
                chk("sb_regime", 64'(out_regime), 64'(sb_e.r));
                chk("sb_timeout", 64'(out_timeout), 64'(sb_e.to));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] a0, a1, ck, ci;
        logic [2:0]  cr;
        int          lat;
        logic [31:0] ek, ei;
        logic [2:0]  er;
        logic        eto;
        int          elat;
    } vec_t;

    vec_t vecs[6];
    bit   found;
    int   t0, p0, o0, acc;

    task automatic handshake_out();
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", 64'(out_valid), 64'(0));
    endtask

    task automatic drain(input string name);
        found = 0;
        for (int k = 0; k < 800 && !found; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_q.size() == 0 && state_dbg == 3'd0 && fifo_count == '0)
                found = 1;
        end
        chk(name, 64'(found), 64'(1));
    endtask

    initial begin
        //               name        a0            a1            ck            ci            cr      lat ek            ei            er      to  elat
        vecs[0] = '{"single",    32'h00010000, 32'h00020000, 32'h00008000, 32'h00020000, 3'b001, 10, 32'h00008000, 32'h00020000, 3'b001, 0, 12};
        vecs[1] = '{"collision", 32'h00000005, 32'h00000006, 32'h00000111, 32'h00000222, 3'b100, 17, 32'h00000111, 32'h00000222, 3'b100, 0, 19};
        vecs[2] = '{"timeout",   32'h00000007, 32'h00000008, 32'h00000333, 32'h00000444, 3'b010, 18, 32'h00000000, 32'h00000000, 3'b000, 1, 19};
        vecs[3] = '{"fast",      32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 3'b010,  1, 32'h80000000, 32'hFFFFFFFF, 3'b010, 0,  4};
        vecs[4] = '{"stuck",     32'h00000009, 32'h0000000A, 32'h00000001, 32'h00000002, 3'b001, 60, 32'h00000000, 32'h00000000, 3'b000, 1, 19};
        vecs[5] = '{"mid",       32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 32'h0BADF00D, 3'b100,  5, 32'hDEADBEEF, 32'h0BADF00D, 3'b100, 0,  7};

        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_a0 = '0; in_a1 = '0; out_ready = 1'b0;
        lat_fixed = 1; resp_fixed = 1; prog_lat = 1;
        prog_kappa = '0; prog_inv = '0; prog_regime = '0;
        core_kappa = '0; core_inv_kappa = '0; core_regime = '0;

        // reset state, with ena low
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_kappa", 64'(out_kappa), 64'(0));
        chk("rst_inv_kappa", 64'(out_inv_kappa), 64'(0));
        chk("rst_regime", 64'(out_regime), 64'(0));
        chk("rst_timeout", 64'(out_timeout), 64'(0));
        chk("rst_fifo_count", 64'(fifo_count), 64'(0));
        chk("rst_core_a0", 64'(core_a0), 64'(0));
        chk("rst_core_a1", 64'(core_a1), 64'(0));
        chk("rst_core_rdy", 64'(core_data_rdy), 64'(0));
        chk("rst_state", 64'(state_dbg), 64'(0));
        @(posedge clk); #1; rst = 1'b0; ena = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // table-driven single requests
        for (int v = 0; v < 6; v++) begin
            lat_fixed = 1; resp_fixed = 1;
            prog_lat = vecs[v].lat; prog_kappa = vecs[v].ck;
            prog_inv = vecs[v].ci; prog_regime = vecs[v].cr;
            p0 = 0;
            @(posedge clk); #1; in_valid = 1'b1; in_a0 = vecs[v].a0; in_a1 = vecs[v].a1;
            @(negedge clk);
            @(posedge clk); #1; in_valid = 1'b0;
            found = 0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (core_data_rdy) found = 1;
            end
            chk({vecs[v].name, "_pulse_seen"}, 64'(found), 64'(1));
            chk({vecs[v].name, "_core_a0"}, 64'(core_a0), 64'(vecs[v].a0));
            chk({vecs[v].name, "_core_a1"}, 64'(core_a1), 64'(vecs[v].a1));
            t0 = cyc;
            found = 0;
            for (int k = 0; k < 60 && !found; k++) begin
                @(negedge clk);
                if (core_data_rdy) p0++;
                if (out_valid) found = 1;
            end
            chk({vecs[v].name, "_valid_seen"}, 64'(found), 64'(1));
            chk({vecs[v].name, "_latency"}, 64'(cyc - t0), 64'(vecs[v].elat));
            chk({vecs[v].name, "_extra_pulses"}, 64'(p0), 64'(0));
            chk({vecs[v].name, "_kappa"}, 64'(out_kappa), 64'(vecs[v].ek));
            chk({vecs[v].name, "_inv_kappa"}, 64'(out_inv_kappa), 64'(vecs[v].ei));
            chk({vecs[v].name, "_regime"}, 64'(out_regime), 64'(vecs[v].er));
            chk({vecs[v].name, "_timeout"}, 64'(out_timeout), 64'(vecs[v].eto));
            handshake_out();
        end

        // back-pressure: 6 back-to-back pushes with downstream stalled
        lat_fixed = 1; prog_lat = 3; resp_fixed = 0; out_ready = 1'b0;
        acc = 0; o0 = n_out;
        @(posedge clk); #1; in_valid = 1'b1; in_a0 = 32'h100; in_a1 = 32'h200;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            in_a0 = 32'h100 + 32'(acc); in_a1 = 32'h200 + 32'(acc);
        end
        @(negedge clk);
        chk("bp_accepted", 64'(acc), 64'(DEPTH + 1));
        chk("bp_fifo_full", 64'(fifo_count), 64'(DEPTH));
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_out_valid_held", 64'(out_valid), 64'(1));
        @(posedge clk); #1; out_ready = 1'b1;
        for (int c = 0; c < 100 && acc < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc >= 6) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_all_pushed", 64'(acc), 64'(6));
        drain("bp_drain");
        chk("bp_results", 64'(n_out - o0), 64'(6));
        @(posedge clk); #1; out_ready = 1'b0;

        // ena gating during WAIT: timer must freeze, so a stuck core aborts 5 cycles later
        lat_fixed = 1; prog_lat = 40; resp_fixed = 0;
        @(posedge clk); #1; in_valid = 1'b1; in_a0 = 32'hABC; in_a1 = 32'h123;
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (core_data_rdy) found = 1;
        end
        chk("ena_pulse_seen", 64'(found), 64'(1));
        t0 = cyc;
        repeat (4) @(posedge clk);
        #1; ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ena_state_hold", 64'(state_dbg), 64'(3));
            chk("ena_no_valid", 64'(out_valid), 64'(0));
            chk("ena_in_ready", 64'(in_ready), 64'(0));
            chk("ena_no_pulse", 64'(core_data_rdy), 64'(0));
            @(posedge clk);
        end
        #1; ena = 1'b1;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        chk("ena_valid_seen", 64'(found), 64'(1));
        chk("ena_latency", 64'(cyc - t0), 64'(TIMEOUT + 3 + 5));
        chk("ena_timeout", 64'(out_timeout), 64'(1));
        handshake_out();

        // reset while in WAIT with 3 entries queued
        lat_fixed = 1; prog_lat = 30; resp_fixed = 0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; in_valid = 1'b1;
            in_a0 = 32'h5000 + 32'(i); in_a1 = 32'h6000 + 32'(i);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (state_dbg == 3'd3) found = 1;
        end
        chk("rw_reached_wait", 64'(found), 64'(1));
        chk("rw_fifo_count", 64'(fifo_count), 64'(3));
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rw_in_ready_in_rst", 64'(in_ready), 64'(0));
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        req_q.delete();
        p0 = 0;
        @(negedge clk);
        chk("rw_fifo_count_zero", 64'(fifo_count), 64'(0));
        chk("rw_state", 64'(state_dbg), 64'(0));
        chk("rw_kappa", 64'(out_kappa), 64'(0));
        chk("rw_regime", 64'(out_regime), 64'(0));
        chk("rw_core_a0", 64'(core_a0), 64'(0));
        chk("rw_core_a1", 64'(core_a1), 64'(0));
        for (int k = 0; k < 12; k++) begin
            if (out_valid) p0++;
            if (core_data_rdy) p0++;
            @(negedge clk);
        end
        chk("rw_no_spurious", 64'(p0), 64'(0));

        // randomized traffic against the reference queues
        lat_fixed = 0; resp_fixed = 0;
        p0 = n_push; o0 = n_out;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) == 0);
            in_a0     = $urandom;
            in_a1     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_enough_traffic", 64'(n_push - p0 > 10), 64'(1));
        chk("rand_result_count", 64'(n_out - o0), 64'(n_push - p0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
